delay_sched: RTL and testbench

- Round-robin scheduler that shares one 12-bit countdown delay timer among N requesters.
- Each requester asks for a delay of its own cycle count. The block grants the timer to one requester at a time, runs the countdown and returns a one-cycle done pulse to the winner.
- Sits between the project's control FSMs (LCD/ms-delay sequencing) and the single timer resource, replacing per-FSM delay counters.

---
 rtl/delay_sched_pkg.sv | 12 +
 rtl/delay_sched_rr_pick.sv | 34 +++
 rtl/delay_sched.sv | 109 ++++++++++
 tb/tb_delay_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_sched_pkg.sv
// Shared definitions for the delay scheduler: FSM state encoding and default counter width.
package delay_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CW_DEFAULT = 12;

endpackage

// File: rtl/delay_sched_rr_pick.sv
// Combinational round-robin selector: first set request strictly after 'last', wrapping modulo N.
module delay_sched_rr_pick
    import delay_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] winner,
    output logic [N-1:0]  onehot
);

    always_comb begin
        int idx;
        valid  = 1'b0;
        winner = '0;
        onehot = '0;
        idx    = 0;
        // Offsets 1..N so that 'last' itself is considered last of all.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = IW'(idx);
            end
        end
        if (valid) begin
            onehot[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/delay_sched.sv
// Shares one countdown timer among N requesters; grants round-robin, pulses done on expiry.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = CW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*CW-1:0]   cycles_in,
    output logic [N-1:0]      grant,
    output logic [N-1:0]      done,
    output logic              busy,
    output logic [CW-1:0]     remaining
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t          state_q;
    logic [N-1:0]    grant_q;
    logic [N-1:0]    done_q;
    logic            busy_q;
    logic [CW-1:0]   count_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   win_q;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [N-1:0]    pick_onehot;
    logic [CW-1:0]   cyc [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign cyc[gi] = cycles_in[gi*CW +: CW];
        end
    endgenerate

    delay_sched_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_idx),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            last_q  <= IW'(N - 1);
            win_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ST_RUN;
                        grant_q <= pick_onehot;
                        win_q   <= pick_idx;
                        count_q <= cyc[pick_idx];
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Abandonment wins over expiry so a dropped request never sees done.
                    if (!req[win_q]) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                        last_q  <= win_q;
                    end else if (count_q != '0) begin
                        count_q <= count_q - 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= grant_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= win_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign remaining = count_q;

endmodule

// File: tb/tb_delay_sched.sv
// Bench for delay_sched: timeline model of ownership checked every cycle, plus directed literal checks.
module tb_delay_sched;

    localparam int N  = 4;
    localparam int CW = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*CW-1:0]   cycles_in = '0;
    logic [N-1:0]      grant;
    logic [N-1:0]      done;
    logic              busy;
    logic [CW-1:0]     remaining;

    int n_cmp = 0;
    int n_bad = 0;

    delay_sched #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .cycles_in (cycles_in),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    // Model: who owns the timer, its sampled count, and how many edges since the grant.
    int m_owner = -1;
    int m_c     = 0;
    int m_age   = 0;
    int m_last  = N - 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_c = 0; m_age = 0; m_last = N - 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (m_owner < 0 && req[i]) begin
                    m_owner = i;
                    m_c     = int'(cycles_in[i*CW +: CW]);
                    m_age   = 0;
                end
            end
        end else if (m_age == m_c + 1) begin
            m_last = m_owner; m_owner = -1;
        end else if (!req[m_owner]) begin
            m_last = m_owner; m_owner = -1;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [N-1:0]  e_grant;
            logic [N-1:0]  e_done;
            logic          e_busy;
            logic [CW-1:0] e_rem;
            e_grant = '0; e_done = '0; e_busy = 1'b0; e_rem = '0;
            if (m_owner >= 0) begin
                e_grant[m_owner] = 1'b1;
                e_busy = 1'b1;
                if (m_age <= m_c) e_rem = CW'(m_c - m_age);
                if (m_age == m_c + 1) e_done[m_owner] = 1'b1;
            end
            n_cmp++;
            if (grant !== e_grant || done !== e_done || busy !== e_busy || remaining !== e_rem) begin
                n_bad++;
                $display("FAIL model t=%0t grant=%b/%b done=%b/%b busy=%b/%b rem=%0d/%0d (got/required)",
                         $time, grant, e_grant, done, e_done, busy, e_busy, remaining, e_rem);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic set_cyc(input int i, input int v);
        cycles_in[i*CW +: CW] = CW'(v);
    endtask

    task automatic wait_grant(input string name);
        bit seen;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (grant != '0) seen = 1;
        end
        if (!seen) chk({name, "_grant_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (done != '0) seen = 1;
        end
        if (!seen) chk({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rem", int'(remaining), 0);

        // Single run, C=5: remaining 5..0, done six edges after grant
        set_cyc(0, 5);
        req = 4'b0001;
        @(negedge clk);
        chk("c5_grant", int'(grant), 1);
        chk("c5_rem0", int'(remaining), 5);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            chk("c5_rem", int'(remaining), 5 - j);
            chk("c5_nodone", int'(done), 0);
        end
        @(negedge clk);
        chk("c5_done", int'(done), 1);
        chk("c5_busy_done", int'(busy), 1);
        req = 4'b0000;
        @(negedge clk);
        chk("c5_idle_grant", int'(grant), 0);
        chk("c5_idle_busy", int'(busy), 0);
        chk("c5_idle_done", int'(done), 0);

        // C=0: done on the cycle right after grant
        set_cyc(2, 0);
        req = 4'b0100;
        @(negedge clk);
        chk("c0_grant", int'(grant), 4);
        @(negedge clk);
        chk("c0_done", int'(done), 4);
        req = 4'b0000;
        @(negedge clk);
        chk("c0_idle", int'(busy), 0);

        // All four requesting: rotation 0,1,2,3 then 0 again (0 holds req after its first done)
        pulse_reset();
        for (int i = 0; i < N; i++) set_cyc(i, 2);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_grant("rr");
            chk("rr_grant", int'(grant), 1 << order[j]);
            wait_done("rr");
            chk("rr_done", int'(done), 1 << order[j]);
            if (j != 0) req[order[j]] = 1'b0;
        end

        // Abort: requester 1 drops after 3 RUN cycles, pending requester 3 goes next
        set_cyc(1, 10);
        set_cyc(3, 3);
        req = 4'b0010;
        wait_grant("ab");
        chk("ab_grant1", int'(grant), 2);
        req[3] = 1'b1;
        repeat (3) @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        chk("ab_grant_zero", int'(grant), 0);
        chk("ab_nodone", int'(done), 0);
        @(negedge clk);
        chk("ab_grant3", int'(grant), 8);
        wait_done("ab");
        chk("ab_done3", int'(done), 8);
        req = 4'b0000;

        // Asynchronous reset mid-run with remaining at 7
        set_cyc(2, 10);
        req = 4'b0100;
        wait_grant("ar");
        for (int c = 0; c < 20 && remaining != 7; c++) @(negedge clk);
        chk("ar_rem7", int'(remaining), 7);
        #2 rst = 1'b1;
        #1;
        chk("ar_grant", int'(grant), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_rem", int'(remaining), 0);
        chk("ar_done", int'(done), 0);
        req = 4'b0101;
        set_cyc(0, 1);
        set_cyc(2, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_next_grant", int'(grant), 1);
        wait_done("ar0");
        req[0] = 1'b0;
        wait_done("ar2");
        req[2] = 1'b0;

        // cycles_in changed after grant is ignored
        set_cyc(0, 4);
        req = 4'b0001;
        wait_grant("lat");
        chk("lat_rem", int'(remaining), 4);
        set_cyc(0, 100);
        repeat (4) @(negedge clk);
        chk("lat_nodone", int'(done), 0);
        @(negedge clk);
        chk("lat_done", int'(done), 1);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
